// File: rtl/rotary_pkg.sv
// Shared types and helpers for the quadrature rotary decoder.
// Latency: none (types, constants and a combinational lookup only).
// Backpressure: none.
package rotary_pkg;

    // Flops between the raw pin and the filter.
    localparam int SYNC_STAGES = 2;

    // Channel tracking state.
    typedef enum logic {
        ST_UNINIT = 1'b0,
        ST_TRACK  = 1'b1
    } chan_state_t;

    // Classification of one filtered AB transition.
    typedef enum logic [1:0] {
        QS_NONE    = 2'd0,
        QS_FWD     = 2'd1,
        QS_REV     = 2'd2,
        QS_ILLEGAL = 2'd3
    } qstep_t;

    // Quarter-step lookup indexed by {prev_ab, cur_ab}.
    // Forward (clockwise) order is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic qstep_t quad_step(input logic [3:0] prev_cur);
        qstep_t step;
        case (prev_cur)
            4'b0010, 4'b1011, 4'b1101, 4'b0100: step = QS_FWD;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: step = QS_REV;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: step = QS_ILLEGAL;
            default:                            step = QS_NONE;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/rotary_channel.sv
// One encoder channel: 2-flop synchroniser, per-bit debounce, quadrature FSM, detent accumulator, position.
// Latency: a clean pin edge yields step_event FILTER_CYCLES+3 edges after it is first sampled.
// Backpressure: none; pins are sampled every cycle and events are single-cycle pulses.
module rotary_channel
    import rotary_pkg::*;
#(
    parameter int FILTER_CYCLES    = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 16,
    parameter int SATURATE         = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           rotary_in,
    input  logic                 position_clear,
    output logic                 step_event,
    output logic                 step_right,
    output logic                 error_event,
    output logic [POS_WIDTH-1:0] position
);

    localparam int                      CNT_W    = 8;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic signed [3:0]       SPD_POS  = 4'(STEPS_PER_DETENT);
    localparam logic signed [3:0]       SPD_NEG  = -SPD_POS;
    localparam logic [POS_WIDTH-1:0]    POS_MAX  = {1'b0, {(POS_WIDTH-1){1'b1}}};
    localparam logic [POS_WIDTH-1:0]    POS_MIN  = {1'b1, {(POS_WIDTH-1){1'b0}}};

    logic [SYNC_STAGES-1:0][1:0] sync_q;
    logic [1:0]                  synced_ab;
    logic [1:0]                  stable_ab;
    logic [1:0]                  stable_vld;

    // Shift raw pins through the synchroniser chain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rotary_in};
        end
    end

    assign synced_ab = sync_q[SYNC_STAGES-1];

    for (genvar b = 0; b < 2; b++) begin : g_filt
        logic             bit_stable;
        logic             bit_vld;
        logic [CNT_W-1:0] bit_cnt;

        // Accept a new bit value only after FILTER_CYCLES consecutive differing samples;
        // before the first acceptance, track the synced value and count how long it holds.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                bit_stable <= 1'b0;
                bit_vld    <= 1'b0;
                bit_cnt    <= '0;
            end else if (!bit_vld) begin
                if (synced_ab[b] != bit_stable) begin
                    bit_stable <= synced_ab[b];
                    bit_cnt    <= '0;
                end else if (bit_cnt == CNT_LAST) begin
                    bit_vld <= 1'b1;
                    bit_cnt <= '0;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (synced_ab[b] == bit_stable) begin
                bit_cnt <= '0;
            end else if (bit_cnt == CNT_LAST) begin
                bit_stable <= synced_ab[b];
                bit_cnt    <= '0;
            end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end

        assign stable_ab[b]  = bit_stable;
        assign stable_vld[b] = bit_vld;
    end

    chan_state_t          state_q, state_d;
    logic [1:0]           prev_q, prev_d;
    logic signed [2:0]    acc_q, acc_d;
    logic [POS_WIDTH-1:0] pos_q, pos_d;
    logic                 step_ev_q, step_ev_d;
    logic                 step_rt_q, step_rt_d;
    logic                 err_ev_q, err_ev_d;
    logic signed [3:0]    acc_sum;
    qstep_t               qs;

    // State and datapath registers for the decoder.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_UNINIT;
            prev_q    <= 2'b00;
            acc_q     <= '0;
            pos_q     <= '0;
            step_ev_q <= 1'b0;
            step_rt_q <= 1'b0;
            err_ev_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            acc_q     <= acc_d;
            pos_q     <= pos_d;
            step_ev_q <= step_ev_d;
            step_rt_q <= step_rt_d;
            err_ev_q  <= err_ev_d;
        end
    end

    // Classify the filtered transition, accumulate quarter-steps and update position.
    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        acc_d     = acc_q;
        pos_d     = pos_q;
        step_ev_d = 1'b0;
        step_rt_d = step_rt_q;
        err_ev_d  = 1'b0;
        acc_sum   = $signed({acc_q[2], acc_q});
        qs        = QS_NONE;

        case (state_q)
            ST_UNINIT: begin
                // First trusted value is only a reference point, never a step.
                if (&stable_vld) begin
                    prev_d  = stable_ab;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                prev_d = stable_ab;
                qs     = quad_step({prev_q, stable_ab});
                case (qs)
                    QS_FWD:  acc_sum = $signed({acc_q[2], acc_q}) + 4'sd1;
                    QS_REV:  acc_sum = $signed({acc_q[2], acc_q}) - 4'sd1;
                    default: acc_sum = $signed({acc_q[2], acc_q});
                endcase
                if (qs == QS_ILLEGAL) begin
                    // A skipped state means the direction is unknown: drop partial progress.
                    err_ev_d = 1'b1;
                    acc_d    = '0;
                end else if (acc_sum == SPD_POS) begin
                    step_ev_d = 1'b1;
                    step_rt_d = 1'b1;
                    acc_d     = '0;
                    if (!(SATURATE != 0 && pos_q == POS_MAX)) begin
                        pos_d = pos_q + POS_WIDTH'(1);
                    end
                end else if (acc_sum == SPD_NEG) begin
                    step_ev_d = 1'b1;
                    step_rt_d = 1'b0;
                    acc_d     = '0;
                    if (!(SATURATE != 0 && pos_q == POS_MIN)) begin
                        pos_d = pos_q - POS_WIDTH'(1);
                    end
                end else begin
                    acc_d = acc_sum[2:0];
                end
            end
            default: state_d = ST_UNINIT;
        endcase

        // Clear overrides any step on the same cycle, but leaves the accumulator alone.
        if (position_clear) begin
            pos_d = '0;
        end
    end

    assign step_event  = step_ev_q;
    assign step_right  = step_rt_q;
    assign error_event = err_ev_q;
    assign position    = pos_q;

endmodule

// File: rtl/rotary_decoder.sv
// Multi-channel quadrature decoder: NUM_CH independent rotary_channel instances on flattened buses.
// Latency: a clean pin edge yields step_event FILTER_CYCLES+3 edges after it is first sampled.
// Backpressure: none; pins are sampled every cycle and events are single-cycle pulses.
module rotary_decoder #(
    parameter int NUM_CH           = 2,
    parameter int FILTER_CYCLES    = 4,
    parameter int STEPS_PER_DETENT = 4,
    parameter int POS_WIDTH        = 16,
    parameter int SATURATE         = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [2*NUM_CH-1:0]         rotary_in,
    input  logic [NUM_CH-1:0]           position_clear,
    output logic [NUM_CH-1:0]           step_event,
    output logic [NUM_CH-1:0]           step_right,
    output logic [NUM_CH-1:0]           error_event,
    output logic [NUM_CH*POS_WIDTH-1:0] position
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        rotary_channel #(
            .FILTER_CYCLES    (FILTER_CYCLES),
            .STEPS_PER_DETENT (STEPS_PER_DETENT),
            .POS_WIDTH        (POS_WIDTH),
            .SATURATE         (SATURATE)
        ) u_chan (
            .clock          (clock),
            .reset          (reset),
            .rotary_in      (rotary_in[2*ch +: 2]),
            .position_clear (position_clear[ch]),
            .step_event     (step_event[ch]),
            .step_right     (step_right[ch]),
            .error_event    (error_event[ch]),
            .position       (position[ch*POS_WIDTH +: POS_WIDTH])
        );
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: directed detent/glitch/error/reset/saturation/clear cases plus random rotation.
// Latency: checks first-step latency of FILTER_CYCLES+3 sampled edges.
// Backpressure: none.
`timescale 1ns/1ps
module tb_rotary_decoder;

    localparam int NCH   = 2;
    localparam int FC    = 4;
    localparam int SPD_A = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic [2*NCH-1:0]  rin_a;
    logic [NCH-1:0]    clr_a;
    logic [NCH-1:0]    step_a, right_a, err_a;
    logic [NCH*16-1:0] pos_a;

    logic [1:0] rin_s, rin_w;
    logic [0:0] clr_s, clr_w, step_s, right_s, err_s, step_w, right_w, err_w;
    logic [3:0] pos_s, pos_w;

    rotary_decoder #(.NUM_CH(NCH), .FILTER_CYCLES(FC), .STEPS_PER_DETENT(SPD_A), .POS_WIDTH(16), .SATURATE(0)) dut_a (
        .clock(clock), .reset(reset), .rotary_in(rin_a), .position_clear(clr_a),
        .step_event(step_a), .step_right(right_a), .error_event(err_a), .position(pos_a));

    rotary_decoder #(.NUM_CH(1), .FILTER_CYCLES(FC), .STEPS_PER_DETENT(4), .POS_WIDTH(4), .SATURATE(1)) dut_s (
        .clock(clock), .reset(reset), .rotary_in(rin_s), .position_clear(clr_s),
        .step_event(step_s), .step_right(right_s), .error_event(err_s), .position(pos_s));

    rotary_decoder #(.NUM_CH(1), .FILTER_CYCLES(FC), .STEPS_PER_DETENT(1), .POS_WIDTH(4), .SATURATE(0)) dut_w (
        .clock(clock), .reset(reset), .rotary_in(rin_w), .position_clear(clr_w),
        .step_event(step_w), .step_right(right_w), .error_event(err_w), .position(pos_w));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Quadrature cycle position -> AB code: 00, 10, 11, 01.
    int gray_ab [4] = '{0, 2, 3, 1};

    // Event counters, updated on the falling edge.
    int steps_a [NCH];
    int errs_a  [NCH];
    int steps_s = 0, steps_w = 0, errs_s = 0;

    always @(negedge clock) begin
        for (int c = 0; c < NCH; c++) begin
            if (step_a[c]) steps_a[c]++;
            if (err_a[c])  errs_a[c]++;
        end
        if (step_s[0]) steps_s++;
        if (step_w[0]) steps_w++;
        if (err_s[0])  errs_s++;
    end

    // Reference model for the random phase: cycle index, quarter-step count, position.
    int midx [NCH];
    int macc [NCH];
    int mpos [NCH];
    int mdir [NCH];
    int errs_exp [NCH];
    int exp_q [NCH][$];
    bit mon_en = 1'b0;

    task automatic model_move(input int c, input int d);
        midx[c] = (midx[c] + d + 4) % 4;
        if (d == 2) begin
            errs_exp[c]++;
            macc[c] = 0;
        end else begin
            macc[c] += d;
            if (macc[c] == SPD_A) begin
                mpos[c] = (mpos[c] + 1) & 32'hFFFF;
                exp_q[c].push_back(mpos[c] | (1 << 16));
                macc[c] = 0;
            end else if (macc[c] == -SPD_A) begin
                mpos[c] = (mpos[c] - 1) & 32'hFFFF;
                exp_q[c].push_back(mpos[c]);
                macc[c] = 0;
            end
        end
    endtask

    // Scoreboard: every step pulse must match the next expected {direction, position}.
    always @(negedge clock) begin
        if (mon_en) begin
            for (int c = 0; c < NCH; c++) begin
                if (step_a[c]) begin
                    chk("rnd_step_expected", longint'(exp_q[c].size() > 0), 1);
                    if (exp_q[c].size() > 0) begin
                        chk("rnd_step_dir_pos", (longint'(right_a[c]) << 16) | longint'(pos_a[c*16 +: 16]),
                            exp_q[c].pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(12);
    endtask

    task automatic drive_a0(input logic [1:0] v, input int hold);
        rin_a[1:0] = v;
        tick(hold);
    endtask

    int s0, e0, e1, lat;
    logic [1:0] pin_v;
    int seg_left [NCH];
    int glitch_left [NCH];
    int glitch_bit [NCH];
    int r;

    initial begin
        reset = 1'b0;
        rin_a = '0; clr_a = '0;
        rin_s = 2'b00; rin_w = 2'b00; clr_s = 1'b0; clr_w = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            steps_a[c] = 0; errs_a[c] = 0;
        end

        // Reset values, then ch0 held at 11: must settle silently.
        rin_a[1:0] = 2'b11;
        tick(1);
        reset = 1'b1;
        tick(2);
        chk("rst_step_event", step_a, 0);
        chk("rst_error_event", err_a, 0);
        chk("rst_step_right", right_a, 0);
        chk("rst_position", pos_a, 0);
        reset = 1'b0;
        s0 = steps_a[0]; e0 = errs_a[0];
        tick(10);
        chk("hold11_steps", steps_a[0] - s0, 0);
        chk("hold11_errs", errs_a[0] - e0, 0);
        chk("hold11_pos", pos_a[15:0], 0);

        // One clockwise detent with first-step latency.
        rin_a = '0;
        do_reset();
        s0 = steps_a[0];
        drive_a0(2'b10, 8);
        drive_a0(2'b11, 8);
        drive_a0(2'b01, 8);
        chk("detent_early", steps_a[0] - s0, 0);
        rin_a[1:0] = 2'b00;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            tick(1);
            if (step_a[0]) begin
                lat = n;
                break;
            end
        end
        chk("detent_latency", lat, FC + 3);
        chk("detent_right", right_a[0], 1);
        chk("detent_pos", pos_a[15:0], 1);
        tick(8);
        chk("detent_count", steps_a[0] - s0, 1);

        // Three reverse quarter-steps, then a short A glitch that would complete a left detent.
        s0 = steps_a[0]; e0 = errs_a[0];
        drive_a0(2'b01, 8);
        drive_a0(2'b11, 8);
        drive_a0(2'b10, 8);
        drive_a0(2'b00, 2);
        drive_a0(2'b10, 12);
        chk("glitch_steps", steps_a[0] - s0, 0);
        chk("glitch_errs", errs_a[0] - e0, 0);
        drive_a0(2'b00, 10);
        chk("left_steps", steps_a[0] - s0, 1);
        chk("left_right", right_a[0], 0);
        chk("left_pos", pos_a[15:0], 0);

        // Two-bit glitch just below the filter length must not look like an illegal jump.
        e0 = errs_a[0];
        drive_a0(2'b11, FC - 1);
        drive_a0(2'b00, 12);
        chk("glitch2_errs", errs_a[0] - e0, 0);

        // ch1 illegal jump 00 -> 11.
        s0 = steps_a[0]; e0 = errs_a[0]; e1 = errs_a[1];
        rin_a[3:2] = 2'b11;
        tick(12);
        chk("illegal_err1", errs_a[1] - e1, 1);
        chk("illegal_pos1", pos_a[31:16], 0);
        chk("illegal_ch0_steps", steps_a[0] - s0, 0);
        chk("illegal_ch0_errs", errs_a[0] - e0, 0);

        // Reset mid-rotation: partial progress is discarded, new value captured silently.
        rin_a = '0;
        do_reset();
        s0 = steps_a[0];
        drive_a0(2'b10, 8); drive_a0(2'b11, 8); drive_a0(2'b01, 8); drive_a0(2'b00, 8);
        chk("midrst_pre_pos", pos_a[15:0], 1);
        drive_a0(2'b10, 8); drive_a0(2'b11, 8);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(12);
        chk("midrst_pos", pos_a[15:0], 0);
        s0 = steps_a[0];
        drive_a0(2'b01, 8); drive_a0(2'b00, 8);
        chk("midrst_no_step", steps_a[0] - s0, 0);
        drive_a0(2'b10, 8); drive_a0(2'b11, 10);
        chk("midrst_step", steps_a[0] - s0, 1);
        chk("midrst_step_pos", pos_a[15:0], 1);

        // Random rotation on both channels against the reference model.
        rin_a = '0;
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            midx[c] = 0; macc[c] = 0; mpos[c] = 0; mdir[c] = 1;
            errs_exp[c] = errs_a[c];
            seg_left[c] = 0; glitch_left[c] = 0; glitch_bit[c] = 0;
            exp_q[c].delete();
        end
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (seg_left[c] == 0) begin
                    r = $urandom_range(0, 9);
                    if (r <= 6) begin
                        if ($urandom_range(0, 4) == 0) mdir[c] = -mdir[c];
                        model_move(c, mdir[c]);
                    end else if (r == 7) begin
                        model_move(c, 2);
                    end else if (r == 8) begin
                        glitch_left[c] = $urandom_range(1, FC - 1);
                        glitch_bit[c]  = $urandom_range(0, 1);
                    end
                    seg_left[c] = glitch_left[c] + $urandom_range(6, 12);
                end
                pin_v = 2'(gray_ab[midx[c]]);
                if (glitch_left[c] > 0) begin
                    pin_v[glitch_bit[c]] = ~pin_v[glitch_bit[c]];
                    glitch_left[c]--;
                end
                rin_a[2*c +: 2] = pin_v;
                seg_left[c]--;
            end
            tick(1);
        end
        tick(20);
        mon_en = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            chk("rnd_leftover_steps", exp_q[c].size(), 0);
            chk("rnd_errs", errs_a[c], errs_exp[c]);
            chk("rnd_pos", pos_a[c*16 +: 16], mpos[c]);
        end

        // Saturation: 4-bit position, 9 right detents.
        rin_a = '0;
        do_reset();
        s0 = steps_s;
        for (int q = 1; q <= 36; q++) begin
            rin_s = 2'(gray_ab[q % 4]);
            tick(7);
            if (q == 28) chk("sat_pos7", $signed(pos_s), 7);
            if (q == 32) chk("sat_pos8", $signed(pos_s), 7);
        end
        tick(8);
        chk("sat_pos9", $signed(pos_s), 7);
        chk("sat_steps", steps_s - s0, 9);
        chk("sat_errs", errs_s, 0);

        // Wrap: 4-bit position, one quarter-step per detent.
        s0 = steps_w;
        for (int q = 1; q <= 9; q++) begin
            rin_w = 2'(gray_ab[q % 4]);
            tick(7);
            if (q == 7) chk("wrap_pos7", $signed(pos_w), 7);
            if (q == 8) chk("wrap_pos8", $signed(pos_w), -8);
            if (q == 9) chk("wrap_pos9", $signed(pos_w), -7);
        end
        chk("wrap_steps", steps_w - s0, 9);

        // Clear coincident with a left step: clear wins for position only.
        rin_w = 2'b00;
        tick(FC + 2);
        clr_w = 1'b1;
        tick(1);
        clr_w = 1'b0;
        chk("clr_step_event", step_w, 1);
        chk("clr_step_right", right_w, 0);
        chk("clr_pos", $signed(pos_w), 0);
        tick(4);
        chk("clr_pos_hold", $signed(pos_w), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
